qwi16_gpio_in_debounce: RTL and testbench
=========================================

// Module: qwi16_gpio_in_debounce
// PURPOSE
//  Input-side counterpart of the PS GPIO LED outputs: samples async board pushbuttons/switches,
//  synchronises and debounces each bit, and drives clean levels to PS GPIO tri_i inputs.
//  Per-bit edge events are latched sticky and raise a level interrupt to the PS.
//  Sits in the PL top wrapper between board pins and the system block GPIO input ports.
// PARAMETERS
//  N_IN            4        number of independent input bits
//  DEBOUNCE_CYCLES 1000000  consecutive stable clocks required to accept a change (10 ms @ 100 MHz); >= 2
//  EDGE_MODE       0        event source: 0 = rising edge, 1 = falling edge, 2 = both edges
//  CNT_W           $clog2(DEBOUNCE_CYCLES)  counter width (derived, not overridden)
// PORTS
//  clk          in   1      system clock (PS FCLK)
//  rst_n        in   1      synchronous active-low reset
//  btn_in       in   N_IN   raw asynchronous board inputs, active-high
//  gpio_tri_i   out  N_IN   debounced stable levels to PS GPIO tri_i
//  evt_clr      in   N_IN   write-1-to-clear pulse per bit, from PS GPIO tri_o
//  evt_pending  out  N_IN   sticky per-bit event flags
//  irq          out  1      registered OR of evt_pending
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): sync FFs, gpio_tri_i, counters, evt_pending, irq all 0. Applies mid-count/mid-event; no event generated by reset release.
//  - Sync: 2-FF synchroniser per bit -> sync[i]; 2-cycle latency.
//  - Debounce per bit: sync[i]==gpio_tri_i[i] -> cnt[i]<=0.
//    sync[i]!=gpio_tri_i[i] and cnt[i]<DEBOUNCE_CYCLES-1 -> cnt[i]++.
//    sync[i]!=gpio_tri_i[i] and cnt[i]==DEBOUNCE_CYCLES-1 -> gpio_tri_i[i]<=sync[i], cnt[i]<=0.
//    Any glitch back to the stable value restarts the count from 0; counter never wraps.
//  - Latency: clean input step -> gpio_tri_i changes exactly DEBOUNCE_CYCLES+2 clocks after first sampling edge.
//  - Edge detect: event[i] asserted on the cycle gpio_tri_i[i] updates, filtered by EDGE_MODE.
//  - Sticky: event[i] -> evt_pending[i]<=1; evt_clr[i] & !event[i] -> evt_pending[i]<=0;
//    simultaneous event and clear -> set wins (no lost event). evt_clr on idle bit: no effect.
//  - irq <= |evt_pending (1-cycle after evt_pending); level, deasserts 1 cycle after last flag clears.
//  - Bits fully independent; simultaneous changes on several bits handled in parallel.
// CONFIGURATION
//  QWI16_GPIO_IN_IRQ_EN defined: edge detect, evt_pending and irq implemented as above.
//  Not defined: event logic removed; evt_pending and irq tied 0, evt_clr ignored;
//    gpio_tri_i debounce path unchanged.
// TESTING  (DEBOUNCE_CYCLES=8, N_IN=4, EDGE_MODE=0, IRQ_EN defined unless stated)
//  1 reset: btn_in=4'hF held during rst_n=0 -> gpio_tri_i=0, evt_pending=0, irq=0; rises 10 clks after release.
//  2 clean step btn_in[0] 0->1 -> gpio_tri_i[0]=1 exactly 10 clks later; evt_pending=4'b0001; irq next clk.
//  3 bounce: btn_in[1] high 5 clks, low 1 clk, high steady -> no change until 8 stable clks after last bounce; one event only.
//  4 clear race: event on bit2 same cycle as evt_clr=4'b0100 -> evt_pending[2] stays 1; clr next cycle -> 0, irq 0 one clk later.
//  5 EDGE_MODE=2, bit3 press then release -> two events, each re-set after intermediate clear; EDGE_MODE=1 -> release only.
//  6 mid-count reset: rst_n=0 at cnt=5 -> all outputs 0, count restarts from 0; macro undefined -> irq/evt_pending stay 0 throughout.

Source files
------------

// File: rtl/qwi16_gpio_in_debounce.sv
// rtl/qwi16_gpio_in_debounce.sv - synchronise and debounce board inputs, optional sticky edge events with irq
// Optional event/interrupt logic is built only when QWI16_GPIO_IN_IRQ_EN is defined.
module qwi16_gpio_in_debounce #(
    parameter int N_IN            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int EDGE_MODE       = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] btn_in,
    output logic [N_IN-1:0] gpio_tri_i,
    input  logic [N_IN-1:0] evt_clr,
    output logic [N_IN-1:0] evt_pending,
    output logic            irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]            meta;
    logic [N_IN-1:0]            sync_q;
    logic [N_IN-1:0]            level;
    logic [N_IN-1:0][CNT_W-1:0] cnt;
    logic [N_IN-1:0]            accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= '0;
            sync_q <= '0;
        end else begin
            meta   <= btn_in;
            sync_q <= meta;
        end
    end

    // A bit is accepted on the clock its mismatch has persisted DEBOUNCE_CYCLES edges.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_IN; i++) begin
            accept[i] = (sync_q[i] != level[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_q[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    cnt[i]   <= '0;
                    level[i] <= sync_q[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign gpio_tri_i = level;

`ifdef QWI16_GPIO_IN_IRQ_EN
    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] fall;
    logic [N_IN-1:0] evt;
    logic [N_IN-1:0] pending;
    logic            irq_q;

    always_comb begin
        rise = accept & sync_q;
        fall = accept & ~sync_q;
        evt  = '0;
        case (EDGE_MODE)
            0:       evt = rise;
            1:       evt = fall;
            default: evt = rise | fall;
        endcase
    end

    // Set dominates clear so an event landing with a clear is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            irq_q   <= 1'b0;
        end else begin
            pending <= (pending & ~evt_clr) | evt;
            irq_q   <= |pending;
        end
    end

    assign evt_pending = pending;
    assign irq         = irq_q;
`else
    logic unused_evt_clr;

    assign unused_evt_clr = ^evt_clr;
    assign evt_pending    = '0;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_qwi16_gpio_in_debounce.sv
// tb/tb_qwi16_gpio_in_debounce.sv - random stimulus against a cycle history reference model, three edge modes
module tb_qwi16_gpio_in_debounce;

    localparam int N = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_in;
    logic [N-1:0] evt_clr;
    logic [N-1:0] gpio_o [3];
    logic [N-1:0] pend_o [3];
    logic         irq_o  [3];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    qwi16_gpio_in_debounce #(.N_IN(N), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .gpio_tri_i(gpio_o[0]),
        .evt_clr(evt_clr), .evt_pending(pend_o[0]), .irq(irq_o[0]));
    qwi16_gpio_in_debounce #(.N_IN(N), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .gpio_tri_i(gpio_o[1]),
        .evt_clr(evt_clr), .evt_pending(pend_o[1]), .irq(irq_o[1]));
    qwi16_gpio_in_debounce #(.N_IN(N), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) u_m2 (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .gpio_tri_i(gpio_o[2]),
        .evt_clr(evt_clr), .evt_pending(pend_o[2]), .irq(irq_o[2]));

    // Reference: btn seen at evaluation edge t is the value sampled at edge t-2;
    // a level flips on the D-th consecutive edge that disagrees with it.
    int unsigned  cyc = 0;
    logic [N-1:0] samp [4];
    logic [N-1:0] m_lvl = '0;
    int           m_run [N];
    logic [N-1:0] m_pend [3];
    logic         m_irq [3];

    initial begin
        for (int b = 0; b < N; b++) m_run[b] = 0;
        for (int k = 0; k < 4; k++) samp[k] = '0;
        for (int m = 0; m < 3; m++) begin
            m_pend[m] = '0;
            m_irq[m]  = 1'b0;
        end
    end

    always @(posedge clk) begin
        logic [N-1:0] seen;
        logic [N-1:0] up;
        logic [N-1:0] down;
        logic [N-1:0] ev;
        if (!rst_n) begin
            m_lvl = '0;
            for (int b = 0; b < N; b++) m_run[b] = 0;
            for (int m = 0; m < 3; m++) begin
                m_pend[m] = '0;
                m_irq[m]  = 1'b0;
            end
            samp[cyc % 4]       = '0;
            samp[(cyc + 3) % 4] = '0;
        end else begin
            seen = samp[(cyc + 2) % 4];
            up   = '0;
            down = '0;
            for (int b = 0; b < N; b++) begin
                if (seen[b] != m_lvl[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == D) begin
                        m_lvl[b] = seen[b];
                        m_run[b] = 0;
                        if (seen[b]) up[b] = 1'b1;
                        else         down[b] = 1'b1;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            for (int m = 0; m < 3; m++) begin
                ev = (m == 0) ? up : (m == 1) ? down : (up | down);
                m_irq[m]  = |m_pend[m];
                m_pend[m] = (m_pend[m] & ~evt_clr) | ev;
            end
            samp[cyc % 4] = btn_in;
        end
        cyc = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            check_eq($sformatf("gpio_m%0d", m), 32'(gpio_o[m]), 32'(m_lvl));
`ifdef QWI16_GPIO_IN_IRQ_EN
            check_eq($sformatf("pend_m%0d", m), 32'(pend_o[m]), 32'(m_pend[m]));
            check_eq($sformatf("irq_m%0d", m), 32'(irq_o[m]), 32'(m_irq[m]));
`else
            check_eq($sformatf("pend_m%0d", m), 32'(pend_o[m]), 32'd0);
            check_eq($sformatf("irq_m%0d", m), 32'(irq_o[m]), 32'd0);
`endif
        end
    endtask

    initial begin
        int lat;
        int flip_div;
        rst_n   = 1'b0;
        btn_in  = 4'hF;
        evt_clr = '0;
        repeat (4) tick();
        rst_n = 1'b1;
        lat   = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (gpio_o[0] == 4'hF && lat == 0) lat = n;
        end
        check_eq("rst_release_latency", 32'(lat), 32'd10);

        btn_in[0] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (gpio_o[0][0] == 1'b0 && lat == 0) lat = n;
        end
        check_eq("step_latency", 32'(lat), 32'd10);

        flip_div = 40;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) flip_div = ($urandom % 2 == 0) ? 40 : 4;
            rst_n = ($urandom % 300 == 0) ? 1'b0 : 1'b1;
            for (int b = 0; b < N; b++) begin
                if ($urandom % flip_div == 0) btn_in[b] = ~btn_in[b];
                evt_clr[b] = ($urandom % 6 == 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
